// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains a synchronous FIFO one word at a time and transmits each
//            word as an 8N1-style serial frame on o_txd (start, LSB first, stop).
// Options  : FIFO_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int WIDTH    = 8,
    parameter int BAUD_DIV = 434
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_empty,
    input  logic [WIDTH-1:0] i_q,
    output logic             o_rd,
    output logic             o_txd,
    output logic             o_busy,
    output logic             o_tx_done
);

    localparam int c_CNT_W = $clog2(BAUD_DIV);
    localparam int c_BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(WIDTH - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5,
        S_PARITY = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_LATCH  = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_STOP   = 3'd5
    } state_t;
`endif

    state_t             r_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [c_BIT_W-1:0] r_bit;
    logic [WIDTH-1:0]   r_shift;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               r_parity;
`endif

    logic             w_baud_last;
    logic [WIDTH-1:0] w_shift_nxt;

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_shift_nxt = r_shift >> 1;

    // The baud counter is cleared on every state change so each bit is
    // timed from its own start and no drift accumulates across the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
            o_txd     <= 1'b1;
            o_rd      <= 1'b0;
            o_busy    <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            o_rd      <= 1'b0;
            o_tx_done <= 1'b0;
            r_baud    <= r_baud + 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    o_txd  <= 1'b1;
                    if (!i_empty) begin
                        r_state <= S_RD;
                        o_rd    <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                S_RD: begin
                    r_baud  <= '0;
                    r_state <= S_LATCH;
                end
                // FIFO data becomes valid the cycle after the read strobe.
                S_LATCH: begin
                    r_baud   <= '0;
                    r_shift  <= i_q;
`ifdef FIFO_UART_TX_PARITY_EN
                    r_parity <= ^i_q;
`endif
                    o_txd    <= 1'b0;
                    r_state  <= S_START;
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        o_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == c_BIT_LAST) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            o_txd   <= r_parity;
                            r_state <= S_PARITY;
`else
                            o_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= w_shift_nxt;
                            o_txd   <= w_shift_nxt[0];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        o_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        o_tx_done <= 1'b1;
                        o_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    o_txd   <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Scoreboard bench for fifo_uart_tx with a behavioural FIFO and a
//            serial-line decoder; honours FIFO_UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int W    = 8;
    localparam int BAUD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FB    = W + 3;
    localparam int FRAME = 44;
`else
    localparam int FB    = W + 2;
    localparam int FRAME = 40;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         empty = 1'b1;
    logic [W-1:0] q = '0;
    logic         wr = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         rd, txd, busy, tx_done;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;

    logic [W-1:0] fifo[$];
    exp_t         exp_q[$];
    int           fall_q[$];
    int           done_q[$];
    int           rd_q[$];
    bit           mon_on = 1'b0;

    fifo_uart_tx #(.WIDTH(W), .BAUD_DIV(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_empty   (empty),
        .i_q       (q),
        .o_rd      (rd),
        .o_txd     (txd),
        .o_busy    (busy),
        .o_tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        ncyc++;
    end

    // Behavioural FIFO: registered empty flag, data valid the cycle after rd.
    initial forever begin
        @(posedge clk);
        if (wr) fifo.push_back(wdata);
        if (rd) begin
            chk("rd_vs_empty", {31'd0, empty}, 32'd0);
            if (fifo.size() > 0) q <= fifo.pop_front();
        end
        empty <= (fifo.size() == 0);
    end

    // Serial decoder and scoreboard checker.
    initial begin
        logic [FB-1:0] bitv;
        bit   glitch, busy_bad, done_bad;
        int   idx;
        exp_t e;
        bitv = '0; glitch = 0; busy_bad = 0; done_bad = 0; idx = 0;
        forever begin
            @(negedge clk);
            if (rd) rd_q.push_back(ncyc);
            if (!rst_n) begin
                if (mon_on) begin
                    mon_on = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else begin
                if (!mon_on && txd === 1'b0) begin
                    mon_on = 1'b1; idx = 0;
                    glitch = 0; busy_bad = 0; done_bad = 0;
                    fall_q.push_back(ncyc);
                end
                if (mon_on) begin
                    if (idx < FRAME) begin
                        if (idx % BAUD == 0) bitv[idx / BAUD] = txd;
                        else if (txd !== bitv[idx / BAUD]) glitch = 1;
                        if (busy !== 1'b1) busy_bad = 1;
                        if (tx_done !== 1'b0) done_bad = 1;
                        idx++;
                    end else begin
                        mon_on = 1'b0;
                        done_q.push_back(ncyc);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", {24'd0, bitv[W:1]}, 32'hffff_ffff);
                        end else begin
                            e = exp_q.pop_front();
                            chk("frame_data", {24'd0, bitv[W:1]}, {24'd0, e.d});
`ifdef FIFO_UART_TX_PARITY_EN
                            chk("parity_bit", {31'd0, bitv[W+1]}, {31'd0, e.p});
`endif
                            chk("start_stop", {30'd0, bitv[0], bitv[FB-1]}, 32'd1);
                            chk("frame_flags", {27'd0, glitch, busy_bad, done_bad, tx_done, busy},
                                32'b00010);
                        end
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [W-1:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        exp_q.push_back(e);
        wr    = 1'b1;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || mon_on) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, n < maxc}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_fall(input int cnt, input int maxc);
        int n = 0;
        while (fall_q.size() < cnt && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("fall_timeout", {31'd0, n < maxc}, 32'd1);
    endtask

    task automatic clear_logs();
        fall_q.delete();
        done_q.delete();
        rd_q.delete();
    endtask

    initial begin
        int p;
        int f0;
        // Reset and idle
        repeat (4) begin
            @(negedge clk);
            chk("reset_outputs", {28'd0, txd, rd, busy, tx_done}, 32'b1000);
        end
        #2 rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("idle_outputs", {28'd0, txd, rd, busy, tx_done}, 32'b1000);
        end

        // Single word
        clear_logs();
        p = ncyc;
        push_word(8'hab, 1'b1);
        wait_idle(300);
        chk("single_rd_count", rd_q.size(), 1);
        chk("single_frames", done_q.size(), 1);
        if (rd_q.size() == 1 && fall_q.size() == 1 && done_q.size() == 1) begin
            chk("single_rd_time", rd_q[0] - p, 2);
            chk("single_fall_time", fall_q[0] - p, 4);
            chk("single_frame_len", done_q[0] - fall_q[0], FRAME);
        end

        // Back-to-back, FIFO filled to depth 4
        clear_logs();
        push_word(8'h12, 1'b0);
        push_word(8'h34, 1'b1);
        push_word(8'h56, 1'b0);
        push_word(8'h78, 1'b0);
        wait_idle(800);
        chk("b2b_rd_count", rd_q.size(), 4);
        chk("b2b_frames", done_q.size(), 4);
        if (fall_q.size() == 4 && done_q.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("b2b_gap", fall_q[i] - done_q[i-1], 3);
            chk("b2b_total", done_q[3] - fall_q[0], 4 * FRAME + 9);
        end

        // Second word arrives mid-frame
        clear_logs();
        push_word(8'hab, 1'b1);
        wait_fall(1, 100);
        repeat (15) @(negedge clk);
        push_word(8'h5c, 1'b0);
        wait_idle(400);
        chk("mid_rd_count", rd_q.size(), 2);
        if (rd_q.size() == 2 && fall_q.size() == 2 && done_q.size() == 2) begin
            chk("mid_rd_after_done", rd_q[1] - done_q[0], 1);
            chk("mid_gap", fall_q[1] - done_q[0], 3);
        end

        // Reset during data bit 3
        clear_logs();
        push_word(8'h12, 1'b0);
        push_word(8'h34, 1'b1);
        wait_fall(1, 100);
        f0 = (fall_q.size() > 0) ? fall_q[0] : ncyc;
        while (ncyc < f0 + 17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_out", {30'd0, txd, busy}, 32'b10);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_idle(400);
        repeat (60) @(negedge clk);
        chk("rst_rd_count", rd_q.size(), 2);
        chk("rst_frames_done", done_q.size(), 1);
        chk("rst_falls", fall_q.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", ncyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
